pe_sequencer: RTL and testbench

//  Control FSM for one processing-element datapath (IF/filter readers, read-address generator, MAC pipeline, psum accumulator).

---
 rtl/pe_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pe_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_sequencer.sv
// rtl/pe_sequencer.sv - control FSM for one PE datapath: clear, load, arm, MAC run, flush.
// Optional watchdog with timeout_err port when PE_SEQ_TIMEOUT_EN is defined.
module pe_sequencer #(
   parameter int FLUSH_CYCLES   = 2,
`ifdef PE_SEQ_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES = 1024,
`endif
   parameter int PSUM_CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            num_filt,
   input  logic                  acc_en,
   input  logic                  psum_done,
   input  logic                  full_done,
   input  logic                  stride_pos_ld,
   input  logic                  outbuf_write,
   output logic                  regs_clr,
   output logic                  reset_Filter,
   output logic                  IF_read_start,
   output logic                  filter_read_start,
   output logic                  start_rd_gen,
   output logic                  filter_mux_sel,
   output logic                  reset_accumulation,
   output logic                  accumulate_input_psum,
   output logic                  usage_stride_pos_ld,
   output logic                  busy,
   output logic                  done,
`ifdef PE_SEQ_TIMEOUT_EN
   output logic                  timeout_err,
`endif
   output logic [PSUM_CNT_W-1:0] out_count
);

   localparam int FW = $clog2(FLUSH_CYCLES + 1);
`ifdef PE_SEQ_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wd_cnt;
`endif

   typedef enum logic [2:0] {IDLE, CLR, LOAD, ARM, RUN, NEXT, FLUSH, DONE} state_t;

   state_t        state;
   logic          nf_two;
   logic          filt_idx;
   logic [FW-1:0] flush_cnt;

   // The window only advances once the last filter of the window is active.
   assign usage_stride_pos_ld = (state == RUN) && stride_pos_ld && (filt_idx == nf_two);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                 <= IDLE;
         nf_two                <= 1'b0;
         filt_idx              <= 1'b0;
         flush_cnt             <= '0;
         out_count             <= '0;
         regs_clr              <= 1'b0;
         reset_Filter          <= 1'b0;
         IF_read_start         <= 1'b0;
         filter_read_start     <= 1'b0;
         start_rd_gen          <= 1'b0;
         filter_mux_sel        <= 1'b0;
         reset_accumulation    <= 1'b0;
         accumulate_input_psum <= 1'b0;
         busy                  <= 1'b0;
         done                  <= 1'b0;
`ifdef PE_SEQ_TIMEOUT_EN
         wd_cnt                <= '0;
         timeout_err           <= 1'b0;
`endif
      end else begin
         regs_clr          <= 1'b0;
         reset_Filter      <= 1'b0;
         IF_read_start     <= 1'b0;
         filter_read_start <= 1'b0;
         start_rd_gen      <= 1'b0;
         done              <= 1'b0;
         if (state != IDLE && outbuf_write && out_count != '1)
            out_count <= out_count + 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  state                 <= CLR;
                  nf_two                <= (num_filt >= 2'd2);
                  accumulate_input_psum <= acc_en;
                  filt_idx              <= 1'b0;
                  out_count             <= '0;
                  regs_clr              <= 1'b1;
                  reset_Filter          <= 1'b1;
                  busy                  <= 1'b1;
`ifdef PE_SEQ_TIMEOUT_EN
                  timeout_err           <= 1'b0;
`endif
               end
            end
            CLR: begin
               state             <= LOAD;
               IF_read_start     <= 1'b1;
               filter_read_start <= 1'b1;
            end
            LOAD: begin
               state              <= ARM;
               start_rd_gen       <= 1'b1;
               reset_accumulation <= 1'b0;
            end
            ARM: begin
               state              <= RUN;
               reset_accumulation <= 1'b1;
               filter_mux_sel     <= 1'b0;
`ifdef PE_SEQ_TIMEOUT_EN
               wd_cnt             <= '0;
`endif
            end
            RUN: begin
               reset_accumulation <= 1'b1;
               filter_mux_sel     <= filt_idx;
`ifdef PE_SEQ_TIMEOUT_EN
               wd_cnt             <= psum_done ? '0 : wd_cnt + 1'b1;
`endif
               if (psum_done) begin
                  reset_accumulation <= 1'b0;
                  if (filt_idx != nf_two) begin
                     state          <= NEXT;
                     filt_idx       <= 1'b1;
                     reset_Filter   <= 1'b1;
                     filter_mux_sel <= 1'b1;
                  end else begin
                     filt_idx       <= 1'b0;
                     filter_mux_sel <= 1'b0;
                     if (full_done) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                     end
                  end
               end else if (full_done) begin
                  state              <= FLUSH;
                  flush_cnt          <= '0;
                  reset_accumulation <= 1'b0;
                  filter_mux_sel     <= 1'b0;
               end
`ifdef PE_SEQ_TIMEOUT_EN
               else if (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
                  state              <= FLUSH;
                  flush_cnt          <= '0;
                  reset_accumulation <= 1'b0;
                  filter_mux_sel     <= 1'b0;
                  timeout_err        <= 1'b1;
               end
`endif
            end
            NEXT: begin
               state              <= RUN;
               reset_accumulation <= 1'b1;
               filter_mux_sel     <= 1'b1;
`ifdef PE_SEQ_TIMEOUT_EN
               wd_cnt             <= '0;
`endif
            end
            FLUSH: begin
               if (flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  flush_cnt <= flush_cnt + 1'b1;
               end
            end
            DONE: begin
               state                 <= IDLE;
               busy                  <= 1'b0;
               accumulate_input_psum <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_sequencer.sv
// tb/tb_pe_sequencer.sv - directed self-checking bench for pe_sequencer.
// Watchdog scenario runs only when PE_SEQ_TIMEOUT_EN is defined.
module tb_pe_sequencer;

   logic       clk, rst, start, acc_en, psum_done, full_done, stride_pos_ld, outbuf_write;
   logic [1:0] num_filt;
   logic       regs_clr, reset_Filter, IF_read_start, filter_read_start, start_rd_gen;
   logic       filter_mux_sel, reset_accumulation, accumulate_input_psum, usage_stride_pos_ld;
   logic       busy, done;
   logic [2:0] out_count;
`ifdef PE_SEQ_TIMEOUT_EN
   logic       timeout_err;
`endif

   int checks   = 0;
   int failures = 0;

   // Strobe vector: clr,rstF,IFrs,frs,rdgen,mux,racc,accin,busy,done
   localparam logic [9:0] S_IDLE  = 10'b00_0000_0000;
   localparam logic [9:0] S_CLR   = 10'b11_0000_0010;
   localparam logic [9:0] S_LOAD  = 10'b00_1100_0010;
   localparam logic [9:0] S_ARM   = 10'b00_0010_0010;
   localparam logic [9:0] S_RUN0  = 10'b00_0000_1010;
   localparam logic [9:0] S_RUN1  = 10'b00_0001_1010;
   localparam logic [9:0] S_PSUM  = 10'b00_0000_0010;
   localparam logic [9:0] S_NEXT  = 10'b01_0001_0010;
   localparam logic [9:0] S_FLUSH = 10'b00_0000_0010;
   localparam logic [9:0] S_DONE  = 10'b00_0000_0011;
   localparam logic [9:0] ACC     = 10'b00_0000_0100;

   pe_sequencer #(
      .FLUSH_CYCLES(2),
`ifdef PE_SEQ_TIMEOUT_EN
      .TIMEOUT_CYCLES(16),
`endif
      .PSUM_CNT_W(3)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .num_filt(num_filt), .acc_en(acc_en),
      .psum_done(psum_done), .full_done(full_done), .stride_pos_ld(stride_pos_ld),
      .outbuf_write(outbuf_write), .regs_clr(regs_clr), .reset_Filter(reset_Filter),
      .IF_read_start(IF_read_start), .filter_read_start(filter_read_start),
      .start_rd_gen(start_rd_gen), .filter_mux_sel(filter_mux_sel),
      .reset_accumulation(reset_accumulation), .accumulate_input_psum(accumulate_input_psum),
      .usage_stride_pos_ld(usage_stride_pos_ld), .busy(busy), .done(done),
`ifdef PE_SEQ_TIMEOUT_EN
      .timeout_err(timeout_err),
`endif
      .out_count(out_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [9:0] obs();
      return {regs_clr, reset_Filter, IF_read_start, filter_read_start, start_rd_gen,
              filter_mux_sel, reset_accumulation, accumulate_input_psum, busy, done};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [1:0] nf, input logic ae);
      num_filt = nf;
      acc_en   = ae;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      stride_pos_ld = 1'b1;
      tick();
      checks++; if (obs() !== S_IDLE) begin failures++; $display("FAIL reset_strobes got=%b exp=%b", obs(), S_IDLE); end
      checks++; if (out_count !== 3'd0 || usage_stride_pos_ld !== 1'b0) begin failures++; $display("FAIL reset_count got=%0d/%b exp=0/0", out_count, usage_stride_pos_ld); end
      stride_pos_ld = 1'b0;
      rst = 1'b1;
      tick();
      checks++; if (obs() !== S_IDLE) begin failures++; $display("FAIL idle_no_start got=%b exp=%b", obs(), S_IDLE); end
   endtask

   task automatic test_single_filter();
      num_filt = 2'd1; acc_en = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (obs() !== S_CLR) begin failures++; $display("FAIL single_clr got=%b exp=%b", obs(), S_CLR); end
      tick();
      checks++; if (obs() !== S_LOAD) begin failures++; $display("FAIL single_load got=%b exp=%b", obs(), S_LOAD); end
      tick();
      checks++; if (obs() !== S_ARM) begin failures++; $display("FAIL single_arm got=%b exp=%b", obs(), S_ARM); end
      tick();
      checks++; if (obs() !== S_RUN0) begin failures++; $display("FAIL single_run got=%b exp=%b", obs(), S_RUN0); end
      stride_pos_ld = 1'b1; #1;
      checks++; if (usage_stride_pos_ld !== 1'b1) begin failures++; $display("FAIL single_stride got=%b exp=1", usage_stride_pos_ld); end
      stride_pos_ld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         psum_done = 1'b1; outbuf_write = 1'b1;
         tick();
         psum_done = 1'b0; outbuf_write = 1'b0;
         checks++; if (obs() !== S_PSUM) begin failures++; $display("FAIL single_psum%0d got=%b exp=%b", i, obs(), S_PSUM); end
         tick();
         checks++; if (obs() !== S_RUN0) begin failures++; $display("FAIL single_rerun%0d got=%b exp=%b", i, obs(), S_RUN0); end
      end
      full_done = 1'b1;
      tick();
      full_done = 1'b0;
      checks++; if (obs() !== S_FLUSH) begin failures++; $display("FAIL single_flush1 got=%b exp=%b", obs(), S_FLUSH); end
      tick();
      checks++; if (obs() !== S_FLUSH) begin failures++; $display("FAIL single_flush2 got=%b exp=%b", obs(), S_FLUSH); end
      tick();
      checks++; if (obs() !== S_DONE) begin failures++; $display("FAIL single_done got=%b exp=%b", obs(), S_DONE); end
      checks++; if (out_count !== 3'd3) begin failures++; $display("FAIL single_count got=%0d exp=3", out_count); end
      tick();
      checks++; if (obs() !== S_IDLE || out_count !== 3'd3) begin failures++; $display("FAIL single_idle got=%b/%0d exp=%b/3", obs(), out_count, S_IDLE); end
   endtask

   task automatic test_two_filters();
      start_job(2'd2, 1'b0);
      checks++; if (obs() !== S_RUN0) begin failures++; $display("FAIL two_run0 got=%b exp=%b", obs(), S_RUN0); end
      stride_pos_ld = 1'b1; #1;
      checks++; if (usage_stride_pos_ld !== 1'b0) begin failures++; $display("FAIL two_stride_f0 got=%b exp=0", usage_stride_pos_ld); end
      stride_pos_ld = 1'b0;
      psum_done = 1'b1; tick(); psum_done = 1'b0;
      checks++; if (obs() !== S_NEXT) begin failures++; $display("FAIL two_next got=%b exp=%b", obs(), S_NEXT); end
      tick();
      checks++; if (obs() !== S_RUN1) begin failures++; $display("FAIL two_run1 got=%b exp=%b", obs(), S_RUN1); end
      stride_pos_ld = 1'b1; #1;
      checks++; if (usage_stride_pos_ld !== 1'b1) begin failures++; $display("FAIL two_stride_f1 got=%b exp=1", usage_stride_pos_ld); end
      stride_pos_ld = 1'b0;
      psum_done = 1'b1; tick(); psum_done = 1'b0;
      checks++; if (obs() !== S_PSUM) begin failures++; $display("FAIL two_psum_last got=%b exp=%b", obs(), S_PSUM); end
      tick();
      checks++; if (obs() !== S_RUN0) begin failures++; $display("FAIL two_rerun got=%b exp=%b", obs(), S_RUN0); end
      stride_pos_ld = 1'b1; #1;
      checks++; if (usage_stride_pos_ld !== 1'b0) begin failures++; $display("FAIL two_stride_wrap got=%b exp=0", usage_stride_pos_ld); end
      stride_pos_ld = 1'b0;
      full_done = 1'b1; tick(); full_done = 1'b0;
      outbuf_write = 1'b1; tick(); outbuf_write = 1'b0;
      tick();
      checks++; if (obs() !== S_DONE || out_count !== 3'd1) begin failures++; $display("FAIL two_done got=%b/%0d exp=%b/1", obs(), out_count, S_DONE); end
      tick();
   endtask

   task automatic test_coincide();
      start_job(2'd0, 1'b0);
      psum_done = 1'b1; full_done = 1'b1; tick(); psum_done = 1'b0; full_done = 1'b0;
      checks++; if (obs() !== S_FLUSH) begin failures++; $display("FAIL coin1_flush got=%b exp=%b", obs(), S_FLUSH); end
      tick(); tick();
      checks++; if (obs() !== S_DONE) begin failures++; $display("FAIL coin1_done got=%b exp=%b", obs(), S_DONE); end
      tick();
      start_job(2'd3, 1'b0);
      psum_done = 1'b1; full_done = 1'b1; tick(); psum_done = 1'b0; full_done = 1'b0;
      checks++; if (obs() !== S_NEXT) begin failures++; $display("FAIL coin2_next got=%b exp=%b", obs(), S_NEXT); end
      tick();
      checks++; if (obs() !== S_RUN1) begin failures++; $display("FAIL coin2_run1 got=%b exp=%b", obs(), S_RUN1); end
      full_done = 1'b1; tick(); full_done = 1'b0;
      tick(); tick();
      checks++; if (obs() !== S_DONE) begin failures++; $display("FAIL coin2_done got=%b exp=%b", obs(), S_DONE); end
      tick();
   endtask

   task automatic test_start_ignored();
      num_filt = 2'd2; acc_en = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; acc_en = 1'b0;
      checks++; if (obs() !== (S_CLR | ACC)) begin failures++; $display("FAIL ign_clr got=%b exp=%b", obs(), S_CLR | ACC); end
      repeat (3) tick();
      start = 1'b1; num_filt = 2'd0; tick(); start = 1'b0;
      checks++; if (obs() !== (S_RUN0 | ACC)) begin failures++; $display("FAIL ign_run got=%b exp=%b", obs(), S_RUN0 | ACC); end
      psum_done = 1'b1; tick(); psum_done = 1'b0;
      checks++; if (obs() !== (S_NEXT | ACC)) begin failures++; $display("FAIL ign_latched_nf got=%b exp=%b", obs(), S_NEXT | ACC); end
      tick();
      psum_done = 1'b1; tick(); psum_done = 1'b0;
      full_done = 1'b1; tick(); full_done = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (obs() !== (S_FLUSH | ACC)) begin failures++; $display("FAIL ign_flush got=%b exp=%b", obs(), S_FLUSH | ACC); end
      tick();
      checks++; if (obs() !== (S_DONE | ACC)) begin failures++; $display("FAIL ign_done got=%b exp=%b", obs(), S_DONE | ACC); end
      tick();
      checks++; if (obs() !== S_IDLE) begin failures++; $display("FAIL ign_idle got=%b exp=%b", obs(), S_IDLE); end
   endtask

   task automatic test_mid_reset();
      start_job(2'd1, 1'b1);
      outbuf_write = 1'b1; tick(); outbuf_write = 1'b0;
      stride_pos_ld = 1'b1;
      rst = 1'b0; #1;
      checks++; if (obs() !== S_IDLE || usage_stride_pos_ld !== 1'b0 || out_count !== 3'd0) begin
         failures++; $display("FAIL midrst_outputs got=%b/%b/%0d exp=%b/0/0", obs(), usage_stride_pos_ld, out_count, S_IDLE); end
      rst = 1'b1; stride_pos_ld = 1'b0;
      tick();
      checks++; if (obs() !== S_IDLE) begin failures++; $display("FAIL midrst_idle got=%b exp=%b", obs(), S_IDLE); end
      num_filt = 2'd1; acc_en = 1'b0; start = 1'b1; tick(); start = 1'b0;
      checks++; if (obs() !== S_CLR) begin failures++; $display("FAIL midrst_restart got=%b exp=%b", obs(), S_CLR); end
      repeat (3) tick();
      full_done = 1'b1; tick(); full_done = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_saturate();
      start_job(2'd1, 1'b0);
      outbuf_write = 1'b1;
      repeat (5) tick();
      checks++; if (out_count !== 3'd5) begin failures++; $display("FAIL sat_mid got=%0d exp=5", out_count); end
      repeat (5) tick();
      outbuf_write = 1'b0;
      checks++; if (out_count !== 3'd7) begin failures++; $display("FAIL sat_top got=%0d exp=7", out_count); end
      full_done = 1'b1; tick(); full_done = 1'b0;
      tick(); tick();
      checks++; if (obs() !== S_DONE || out_count !== 3'd7) begin failures++; $display("FAIL sat_done got=%b/%0d exp=%b/7", obs(), out_count, S_DONE); end
      tick();
   endtask

`ifdef PE_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      start_job(2'd1, 1'b0);
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_initial got=%b exp=0", timeout_err); end
      repeat (15) tick();
      checks++; if (obs() !== S_RUN0 || timeout_err !== 1'b0) begin failures++; $display("FAIL to_run16 got=%b/%b exp=%b/0", obs(), timeout_err, S_RUN0); end
      tick();
      checks++; if (obs() !== S_FLUSH || timeout_err !== 1'b1) begin failures++; $display("FAIL to_flush got=%b/%b exp=%b/1", obs(), timeout_err, S_FLUSH); end
      tick(); tick();
      checks++; if (obs() !== S_DONE) begin failures++; $display("FAIL to_done got=%b exp=%b", obs(), S_DONE); end
      tick();
      checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", timeout_err); end
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", timeout_err); end
      repeat (3) tick();
      full_done = 1'b1; tick(); full_done = 1'b0;
      repeat (3) tick();
   endtask
`endif

   initial begin
      rst = 1'b0; start = 1'b0; num_filt = 2'd0; acc_en = 1'b0; psum_done = 1'b0;
      full_done = 1'b0; stride_pos_ld = 1'b0; outbuf_write = 1'b0;
      test_reset();
      test_single_filter();
      test_two_filters();
      test_coincide();
      test_start_ignored();
      test_mid_reset();
      test_saturate();
`ifdef PE_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
